// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache controller.
// The slave modport is the cache's view; the master modport is the pipeline/memory side.
interface icache_ctrl_if;
    logic         CPU_READ_EN;
    logic [31:0]  CPU_ADDR;
    logic [31:0]  CPU_INSTR;
    logic         CPU_BUSYWAIT;
    logic         MEM_READ_EN;
    logic [27:0]  MEM_ADDR;
    logic         MEM_BUSYWAIT;
    logic [127:0] MEM_READ_DATA;

    modport slave (
        input  CPU_READ_EN, CPU_ADDR, MEM_BUSYWAIT, MEM_READ_DATA,
        output CPU_INSTR, CPU_BUSYWAIT, MEM_READ_EN, MEM_ADDR
    );

    modport master (
        output CPU_READ_EN, CPU_ADDR, MEM_BUSYWAIT, MEM_READ_DATA,
        input  CPU_INSTR, CPU_BUSYWAIT, MEM_READ_EN, MEM_ADDR
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with 16-byte lines.
// Hits return in the same cycle; misses refill one block, then re-evaluate in IDLE.
module icache_ctrl #(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic        CLK,
    input  logic        RESET,
    icache_ctrl_if.slave bus
);
    localparam int unsigned LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t                state_q, state_d;
    logic [27:0]           miss_addr_q, miss_addr_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [TAG_BITS-1:0]   tag_d  [LINES];
    logic [127:0]          data_q [LINES];
    logic [127:0]          data_d [LINES];

    logic [INDEX_BITS-1:0] cpu_idx;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [127:0]          cpu_line;
    logic                  hit;

    always_comb begin
        cpu_idx  = bus.CPU_ADDR[3+INDEX_BITS:4];
        cpu_tag  = bus.CPU_ADDR[31:4+INDEX_BITS];
        fill_idx = miss_addr_q[INDEX_BITS-1:0];
        cpu_line = data_q[cpu_idx];
        hit      = bus.CPU_READ_EN && valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        for (int unsigned i = 0; i < LINES; i++) begin
            tag_d[i]  = tag_q[i];
            data_d[i] = data_q[i];
        end
        bus.CPU_INSTR    = cpu_line[{bus.CPU_ADDR[3:2], 5'b0} +: 32];
        bus.CPU_BUSYWAIT = 1'b0;
        bus.MEM_READ_EN  = 1'b0;
        bus.MEM_ADDR     = miss_addr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.CPU_READ_EN && !hit) begin
                    bus.CPU_BUSYWAIT = 1'b1;
                    miss_addr_d      = bus.CPU_ADDR[31:4];
                    state_d          = MEM_READ;
                end
            end
            MEM_READ: begin
                bus.CPU_BUSYWAIT = 1'b1;
                bus.MEM_READ_EN  = 1'b1;
                if (!bus.MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE: begin
                // Block data is held stable by memory through this cycle.
                bus.CPU_BUSYWAIT  = 1'b1;
                valid_d[fill_idx] = 1'b1;
                tag_d[fill_idx]   = miss_addr_q[27:INDEX_BITS];
                data_d[fill_idx]  = bus.MEM_READ_DATA;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data need no reset: valid bits gate their use, and reset leaves state_q
    // out of UPDATE so an aborted refill never writes.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule
